// File: rtl/write_post_buffer_if.sv
// Bundles the CPU write port and the SDRAM write port of the posted-write buffer.
// Latency: none, wires only.
// Backpressure: carried by cpu_ack, full, sdram_req and sdram_ack.
interface write_post_buffer_if;
    logic [31:0] cpu_addr;
    logic        cpu_req;
    logic        cpu_rw;
    logic        cpu_rwl;
    logic        cpu_rwu;
    logic [15:0] data_from_cpu;
    logic        cpu_ack;
    logic [31:0] sdram_addr;
    logic [15:0] data_to_sdram;
    logic        sdram_uds;
    logic        sdram_lds;
    logic        sdram_req;
    logic        sdram_rw;
    logic        sdram_ack;
    logic        full;
    logic        drained;

    // CPU/SDRAM side that drives the buffer
    modport master (
        output cpu_addr, cpu_req, cpu_rw, cpu_rwl, cpu_rwu, data_from_cpu, sdram_ack,
        input  cpu_ack, sdram_addr, data_to_sdram, sdram_uds, sdram_lds, sdram_req,
        input  sdram_rw, full, drained
    );

    // The buffer itself
    modport slave (
        input  cpu_addr, cpu_req, cpu_rw, cpu_rwl, cpu_rwu, data_from_cpu, sdram_ack,
        output cpu_ack, sdram_addr, data_to_sdram, sdram_uds, sdram_lds, sdram_req,
        output sdram_rw, full, drained
    );
endinterface

// File: rtl/write_post_buffer.sv
// Posted-write FIFO: queues CPU writes (merging bytes into the newest word) and drains them to SDRAM.
// Latency: cpu_ack the cycle after acceptance; sdram_req rises the cycle after an entry is present.
// Backpressure: writes wait in C_IDLE while full; the head is held on the SDRAM port until sdram_ack.
module write_post_buffer #(
    parameter int DEPTH    = 4,
    parameter int ADDRBITS = 25
) (
    input logic                clk,
    input logic                reset,
    write_post_buffer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDRBITS-1:0] addr;
        logic                uds_n;
        logic                lds_n;
        logic [15:0]         data;
    } entry_t;

    typedef enum logic {C_IDLE, C_HOLD} cpu_state_t;
    typedef enum logic {S_IDLE, S_BUSY} sd_state_t;

    entry_t              mem [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr, tail_ptr;
    logic [CW-1:0]       count;
    cpu_state_t          cpu_st, cpu_nxt;
    sd_state_t           sd_st, sd_nxt;
    logic                accept, tail_hit, do_merge, do_push, load, pop;
    logic                full_w;
    entry_t              new_ent, merge_ent, head_ent;
    logic [ADDRBITS-1:0] cpu_waddr;
    logic                unused_addr_bits;

    assign cpu_waddr        = bus.cpu_addr[ADDRBITS:1];
    assign unused_addr_bits = ^{bus.cpu_addr[31:ADDRBITS+1], bus.cpu_addr[0]};
    assign tail_ptr         = wr_ptr - PW'(1);
    assign full_w           = (count == CW'(DEPTH));
    assign bus.full         = full_w;
    assign bus.drained      = (count == '0) && !bus.sdram_req;
    assign bus.sdram_rw     = 1'b0;

    // CPU FSM: take one write per CPU cycle, then wait for cpu_req to drop
    always_comb begin
        cpu_nxt = cpu_st;
        accept  = 1'b0;
        case (cpu_st)
            C_IDLE: if (bus.cpu_req && !bus.cpu_rw && !full_w) begin
                accept  = 1'b1;
                cpu_nxt = C_HOLD;
            end
            C_HOLD: if (!bus.cpu_req) cpu_nxt = C_IDLE;
            default: cpu_nxt = C_IDLE;
        endcase
    end

    // CPU FSM state and the one-cycle ack pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_st      <= C_IDLE;
            bus.cpu_ack <= 1'b0;
        end else begin
            cpu_st      <= cpu_nxt;
            bus.cpu_ack <= accept;
        end
    end

    // Merge/push decision; the head load sees a same-cycle merge so no bytes are lost
    always_comb begin
        new_ent = '{addr: cpu_waddr, uds_n: bus.cpu_rwu, lds_n: bus.cpu_rwl, data: bus.data_from_cpu};
        merge_ent = mem[tail_ptr];
        if (!bus.cpu_rwl) begin
            merge_ent.data[7:0] = bus.data_from_cpu[7:0];
            merge_ent.lds_n     = 1'b0;
        end
        if (!bus.cpu_rwu) begin
            merge_ent.data[15:8] = bus.data_from_cpu[15:8];
            merge_ent.uds_n      = 1'b0;
        end
        tail_hit = (count != '0) && (mem[tail_ptr].addr == cpu_waddr) &&
                   !((tail_ptr == rd_ptr) && bus.sdram_req);
        do_merge = accept && tail_hit;
        do_push  = accept && !tail_hit;
        head_ent = (do_merge && (tail_ptr == rd_ptr)) ? merge_ent : mem[rd_ptr];
    end

    // Entry storage: push at the tail or merge into the newest entry
    always_ff @(posedge clk) begin
        if (do_push)       mem[wr_ptr]   <= new_ent;
        else if (do_merge) mem[tail_ptr] <= merge_ent;
    end

    // SDRAM FSM: present the head, hold it until sdram_ack
    always_comb begin
        sd_nxt = sd_st;
        load   = 1'b0;
        pop    = 1'b0;
        case (sd_st)
            S_IDLE: if (count != '0) begin
                load   = 1'b1;
                sd_nxt = S_BUSY;
            end
            S_BUSY: if (bus.sdram_ack) begin
                pop    = 1'b1;
                sd_nxt = S_IDLE;
            end
            default: sd_nxt = S_IDLE;
        endcase
    end

    // SDRAM FSM state and the registered SDRAM port
    always_ff @(posedge clk) begin
        if (reset) begin
            sd_st             <= S_IDLE;
            bus.sdram_req     <= 1'b0;
            bus.sdram_addr    <= '0;
            bus.data_to_sdram <= '0;
            bus.sdram_uds     <= 1'b1;
            bus.sdram_lds     <= 1'b1;
        end else begin
            sd_st <= sd_nxt;
            if (load) begin
                bus.sdram_req     <= 1'b1;
                bus.sdram_addr    <= {{(31-ADDRBITS){1'b0}}, head_ent.addr, 1'b0};
                bus.data_to_sdram <= head_ent.data;
                bus.sdram_uds     <= head_ent.uds_n;
                bus.sdram_lds     <= head_ent.lds_n;
            end else if (pop) begin
                bus.sdram_req <= 1'b0;
            end
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (pop && !do_push) count <= count - CW'(1);
        end
    end
endmodule
